// File: rtl/ifu.sv
// ifu -- instruction fetch unit for the RV64 core.
//
// Owns the architectural fetch PC, issues one word request at a time on the
// instruction bus and buffers returned words in a 2-entry {pc, insn} queue
// presented to decode. An execute-stage redirect (i_flush + i_pc_tgt) clears
// the queue, restarts fetch at the target and, if a response is still
// outstanding, drains that stale response before fetching again.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   i_flush, i_pc_tgt        redirect pulse and 62-bit word target
//   o_imem_req, o_imem_addr  request valid / word-aligned address
//   i_imem_ready             bus accepts the request this cycle
//   i_imem_rvalid, i_imem_rdata  response for the outstanding request
//   o_id_valid, o_id_pc, o_id_insn  queue head presented to decode
//   i_id_ready               decode consumes the head this cycle
module ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_flush,
  input  logic [61:0] i_pc_tgt,
  output logic        o_imem_req,
  output logic [63:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_id_valid,
  output logic [63:0] o_id_pc,
  output logic [31:0] o_id_insn,
  input  logic        i_id_ready
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [63:0] pc_r;
  logic [63:0] req_pc_r;
  logic [1:0]  count_r;
  logic        rd_ptr_r;
  logic        wr_ptr_r;
  logic [63:0] q_pc_r   [2];
  logic [31:0] q_insn_r [2];

  logic        imem_req_s;
  logic        accept_s;
  logic        push_s;
  logic        pop_s;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a response arriving together with a flush is simply
  // dropped, so rvalid always returns WAIT/DRAIN to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (i_imem_rvalid) begin
          state_nxt_s = ST_IDLE;
        end else if (i_flush) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (i_imem_rvalid) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output/control decode: request gating, bus handshake, queue push/pop.
  always_comb begin
    imem_req_s = 1'b0;
    push_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        imem_req_s = (count_r < 2'd2) && !i_flush && !rst;
      end
      ST_WAIT: begin
        push_s = i_imem_rvalid && !i_flush;
      end
      ST_DRAIN: begin
        push_s = 1'b0;
      end
      default: begin
        imem_req_s = 1'b0;
        push_s     = 1'b0;
      end
    endcase
    accept_s = imem_req_s && i_imem_ready;
    pop_s    = (count_r != 2'd0) && i_id_ready && !i_flush;
  end

  // PC, request PC, queue occupancy and pointers; flush overrides all.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r     <= RESET_PC;
      req_pc_r <= 64'd0;
      count_r  <= 2'd0;
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
    end else if (i_flush) begin
      pc_r     <= {i_pc_tgt, 2'b00};
      count_r  <= 2'd0;
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
    end else begin
      if (accept_s) begin
        req_pc_r <= pc_r;
        pc_r     <= pc_r + 64'd4;
      end
      if (push_s) begin
        wr_ptr_r <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Queue payload; contents are only meaningful while counted as valid.
  always_ff @(posedge clk) begin
    if (push_s) begin
      q_pc_r[wr_ptr_r]   <= req_pc_r;
      q_insn_r[wr_ptr_r] <= i_imem_rdata;
    end
  end

  assign o_imem_req  = imem_req_s;
  assign o_imem_addr = pc_r;
  assign o_id_valid  = (count_r != 2'd0);
  assign o_id_pc     = q_pc_r[rd_ptr_r];
  assign o_id_insn   = q_insn_r[rd_ptr_r];

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit for the RV64 core. It owns the architectural fetch PC and issues word requests on the instruction bus, holding at most one request outstanding. Returned instructions are buffered in a 2-entry queue that is presented to decode. It is the receiving end of the execute-stage redirect: it consumes the flush pulse and 62-bit word-aligned target that branch/jump resolution produces, discards wrong-path work and restarts fetch at the target.

## Interface
- `RESET_PC`, default 64'h0000_0000_8000_0000: first fetch address after reset; bits [1:0] must be 0.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_flush` in 1: redirect from execute; single-cycle pulse, may repeat on consecutive cycles.
- `i_pc_tgt` in 62: redirect target word address; fetch PC becomes {i_pc_tgt, 2'b00}; sampled only when i_flush=1.
- `o_imem_req` out 1: request valid.
- `o_imem_addr` out 64: request address, word aligned.
- `i_imem_ready` in 1: bus accepts request this cycle (req && ready).
- `i_imem_rvalid` in 1: response valid for the outstanding request.
- `i_imem_rdata` in 32: instruction word.
- `o_id_valid` out 1: queue head valid.
- `o_id_pc` out 64: PC of queue head.
- `o_id_insn` out 32: instruction of queue head.
- `i_id_ready` in 1: decode consumes head this cycle (valid && ready).

## Operation
- Registers: `pc` (64), `req_pc` (64), `state` {IDLE, WAIT, DRAIN}, 2-entry queue of {pc, insn} with `count` (0..2), read/write pointers.
- o_imem_req = (state==IDLE) && (count<2) && !i_flush && !rst; o_imem_addr = pc.
- Request held, with address stable, until accepted. An accepted request (i_flush=0) sets req_pc <= pc, pc <= pc+4 (64-bit wrap, no fault), and IDLE -> WAIT.
- WAIT with i_imem_rvalid=1 and i_flush=0: push {req_pc, i_imem_rdata}, then WAIT -> IDLE.
- DRAIN with i_imem_rvalid=1: response discarded, no push, DRAIN -> IDLE.
- i_imem_rvalid is ignored in IDLE.
- Pop when o_id_valid && i_id_ready; a simultaneous push and pop leaves count unchanged. Overflow cannot occur because a request is issued only when count<2.
- o_id_valid = (count!=0); o_id_pc/o_id_insn = head entry. Head fields are don't-care when invalid.
- Flush (highest priority, any state):
  - pc <= {i_pc_tgt, 2'b00}.
  - Queue cleared: count=0, pointers reset; any same-cycle pop or push is dropped.
  - State transition:
    - IDLE stays IDLE. No request is issued in the flush cycle, because o_imem_req is gated by i_flush.
    - WAIT -> DRAIN if i_imem_rvalid=0. WAIT -> IDLE if i_imem_rvalid=1, and that response is dropped.
    - DRAIN stays DRAIN if i_imem_rvalid=0, otherwise -> IDLE. Only the latest target is kept.
- Reset values: pc=RESET_PC, req_pc=0, state=IDLE, count=0, pointers 0, o_imem_req=0, o_id_valid=0, o_imem_addr=RESET_PC.
- Reset asserted mid-transaction abandons the outstanding response. The bus must not return rvalid for a pre-reset request after rst deasserts; this is a system-level constraint.

## Timing
- First request: cycle after rst deasserts, address RESET_PC.
- Bus with ready=1 and rvalid on the cycle after acceptance: the instruction appears at o_id_valid on the 2nd cycle after acceptance. Throughput is one instruction every 2 cycles.
- Flush in cycle N: the new request is issued at {i_pc_tgt,00} in N+1 if state becomes IDLE. If state becomes DRAIN, it is issued the cycle after the stale rvalid.
- Decode backpressure: with i_id_ready=0 the queue fills to 2 and then o_imem_req stays 0. Fetch resumes the cycle after a pop leaves count<2.
- All outputs are derived from registered state except o_imem_req, which depends combinationally on i_flush and rst.

## Test plan
- Reset, ready=1, rvalid one cycle after accept, id_ready=1 → requests at 0x80000000, 0x80000004, 0x80000008 every 2 cycles; decode sees matching pc/insn pairs in order.
- id_ready=0 for 10 cycles → count saturates at 2, o_imem_req stays 0, no entries lost. Then id_ready=1 → entries 0x80000000 and 0x80000004 pop, and fetch resumes at 0x80000008.
- i_imem_ready=0 for 3 cycles → o_imem_req stays 1 with o_imem_addr stable; pc advances only on the accepting cycle.
- Flush with i_pc_tgt=62'h2000_0100 while WAIT → state DRAIN; the stale rvalid (insn 0xDEADBEEF) never reaches decode. The next request goes to 0x0000_0000_8000_0400 and the queue is empty.
- Flush coincident with rvalid in WAIT, and flush coincident with pop at count=2 → response dropped, queue empty, state IDLE, and the next request is at the target.
- Two flushes on consecutive cycles (targets A then B) → only B is fetched; exactly one stale response is absorbed. Reset during WAIT → state returns to IDLE and fetch restarts at RESET_PC.
